text_line_renderer: RTL

TEXT_LINE_RENDERER -- requirements
Module: text_line_renderer

---
 rtl/text_pkg.sv | 15 +
 rtl/text_char_buffer.sv | 34 +++
 rtl/text_line_renderer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/text_pkg.sv
// Shared constants and state encoding for the single-line text renderer.
// Latency: none (definitions only).
// Backpressure: not applicable.
package text_pkg;

  localparam logic [6:0] ASCII_SPACE  = 7'h20;
  localparam logic [6:0] ASCII_BS     = 7'h08;
  localparam logic [6:0] ASCII_CURSOR = 7'h5F;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/text_char_buffer.sv
// Character cell storage: one synchronous write port, one combinational read port.
// Latency: read is combinational; a write lands on the next rising edge.
// Backpressure: none; a same-cycle read of the cell being written returns the old value.
module text_char_buffer
  import text_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [6:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [6:0]    o_rdata
);

  logic [6:0] r_mem [DEPTH];

  // Cell storage: every entry reverts to a space on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= ASCII_SPACE;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/text_line_renderer.sv
// Single line of text: append/backspace/clear editing plus per-pixel glyph lookup with blinking cursor.
// Latency: render outputs 1 clock after x/y; a write or backspace shows up in the buffer on the next edge.
// Backpressure: wr_ready low while clearing, while wr_clear is pulsed, and for non-backspace writes when full.
module text_line_renderer
  import text_pkg::*;
#(
  parameter int NUM_CHARS    = 16,
  parameter int CHAR_W       = 16,
  parameter int CHAR_H       = 32,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [6:0]                     wr_char,
  input  logic                           wr_clear,
  input  logic                           frame_start,
  input  logic [9:0]                     x_desired,
  input  logic [9:0]                     y_desired,
  input  logic [9:0]                     x,
  input  logic [9:0]                     y,
  output logic [6:0]                     asciiData,
  output logic [$clog2(CHAR_W)-1:0]      glyph_col,
  output logic [$clog2(CHAR_H)-1:0]      glyph_row,
  output logic                           displayContents,
  output logic [$clog2(NUM_CHARS+1)-1:0] wr_ptr_o
);

  localparam int PW = $clog2(NUM_CHARS + 1);
  localparam int AW = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam int CW = $clog2(CHAR_W);
  localparam int RW = $clog2(CHAR_H);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [10:0]   SPAN_X    = 11'(NUM_CHARS * CHAR_W);
  localparam logic [10:0]   SPAN_Y    = 11'(CHAR_H);
  localparam logic [PW-1:0] PTR_FULL  = PW'(NUM_CHARS);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_CHARS - 1);
  localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_FRAMES - 1);

  state_t        r_state;
  logic [PW-1:0] r_wr_ptr;
  logic [AW-1:0] r_clr_idx;
  logic [BW-1:0] r_blink_cnt;
  logic          r_cursor_on;

  logic          w_is_bs;
  logic          w_accept;
  logic          w_buf_we;
  logic [AW-1:0] w_buf_waddr;
  logic [6:0]    w_buf_wdata;
  logic [AW-1:0] w_buf_raddr;
  logic [6:0]    w_buf_rdata;

  logic [10:0]   w_x11, w_y11, w_xd11, w_yd11;
  logic [10:0]   w_dx, w_dy, w_cell;
  logic          w_active;
  logic          w_cursor_hit;

  assign w_is_bs  = (wr_char == ASCII_BS);
  // Gated by reset so the block never advertises readiness while held in reset.
  assign wr_ready = reset && (r_state == ST_IDLE) && !wr_clear &&
                    ((r_wr_ptr < PTR_FULL) || w_is_bs);
  assign w_accept = wr_valid && wr_ready;
  assign wr_ptr_o = r_wr_ptr;

  // Buffer write source: the clear sweep owns the port; otherwise accepted characters or backspaces.
  always_comb begin
    w_buf_we    = 1'b0;
    w_buf_waddr = r_clr_idx;
    w_buf_wdata = ASCII_SPACE;
    if (r_state == ST_CLEAR) begin
      w_buf_we = 1'b1;
    end else if (w_accept) begin
      if (w_is_bs) begin
        w_buf_we    = (r_wr_ptr != '0);
        w_buf_waddr = AW'(r_wr_ptr - 1'b1);
      end else begin
        w_buf_we    = 1'b1;
        w_buf_waddr = AW'(r_wr_ptr);
        w_buf_wdata = wr_char;
      end
    end
  end

  // Editing FSM: clear request always wins and restarts the sweep from entry 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_wr_ptr  <= '0;
      r_clr_idx <= '0;
    end else if (wr_clear) begin
      r_state   <= ST_CLEAR;
      r_wr_ptr  <= '0;
      r_clr_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (!w_is_bs) begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end else if (r_wr_ptr != '0) begin
              r_wr_ptr <= r_wr_ptr - 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          if (r_clr_idx == LAST_IDX) begin
            r_state   <= ST_IDLE;
            r_clr_idx <= '0;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Cursor blink: toggle visibility every BLINK_FRAMES frame pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blink_cnt <= '0;
      r_cursor_on <= 1'b0;
    end else if (frame_start) begin
      if (r_blink_cnt == BLINK_TOP) begin
        r_blink_cnt <= '0;
        r_cursor_on <= !r_cursor_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  text_char_buffer #(
    .DEPTH (NUM_CHARS),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (reset),
    .i_we    (w_buf_we),
    .i_waddr (w_buf_waddr),
    .i_wdata (w_buf_wdata),
    .i_raddr (w_buf_raddr),
    .o_rdata (w_buf_rdata)
  );

  // Region math is widened to 11 bits so a line placed near 1023 does not wrap back to x=0.
  assign w_x11    = {1'b0, x};
  assign w_y11    = {1'b0, y};
  assign w_xd11   = {1'b0, x_desired};
  assign w_yd11   = {1'b0, y_desired};
  assign w_dx     = w_x11 - w_xd11;
  assign w_dy     = w_y11 - w_yd11;
  assign w_active = (w_x11 >= w_xd11) && (w_x11 < w_xd11 + SPAN_X) &&
                    (w_y11 >= w_yd11) && (w_y11 < w_yd11 + SPAN_Y);
  assign w_cell      = w_dx >> CW;
  assign w_buf_raddr = AW'(w_cell);
  assign w_cursor_hit = r_cursor_on && (r_state == ST_IDLE) &&
                        (r_wr_ptr < PTR_FULL) && (w_cell == 11'(r_wr_ptr));

  // Registered pixel lookup: cell character (or cursor) plus position within the glyph.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      asciiData       <= ASCII_SPACE;
      glyph_col       <= '0;
      glyph_row       <= '0;
      displayContents <= 1'b0;
    end else if (w_active) begin
      asciiData       <= w_cursor_hit ? ASCII_CURSOR : w_buf_rdata;
      glyph_col       <= CW'(w_dx);
      glyph_row       <= RW'(w_dy);
      displayContents <= 1'b1;
    end else begin
      asciiData       <= ASCII_SPACE;
      glyph_col       <= '0;
      glyph_row       <= '0;
      displayContents <= 1'b0;
    end
  end

endmodule
